// File: rtl/cell_score_engine.sv
// Needleman-Wunsch cell scorer: reads diag/up/left scores and residues, writes max to (i,j).
// Optional macro TRACEBACK_DIR_EN adds a dir_data output (00 diag, 01 up, 10 left) valid with wr_en.
module cell_score_engine #(
  parameter int N        = 128,
  parameter int SW       = $clog2(N) + 3,
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int GAP      = -2,
  parameter int AW       = $clog2((N + 1) * (N + 1))
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [$clog2(N):0]     i,
  input  logic [$clog2(N):0]     j,
  input  logic                   end_filling,
  output logic                   en_read,
  output logic                   change_index,
  output logic [$clog2(N)-1:0]   seq_a_addr,
  output logic [$clog2(N)-1:0]   seq_b_addr,
  input  logic [1:0]             seq_a_data,
  input  logic [1:0]             seq_b_data,
  output logic [AW-1:0]          rd_addr,
  input  logic signed [SW-1:0]   rd_data,
  output logic                   wr_en,
  output logic [AW-1:0]          wr_addr,
  output logic signed [SW-1:0]   wr_data,
`ifdef TRACEBACK_DIR_EN
  output logic [1:0]             dir_data,
`endif
  output logic                   done
);

  localparam int IW  = $clog2(N) + 1;
  localparam int SAW = $clog2(N);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_D = 3'd1;
  localparam logic [2:0] S_RD_U = 3'd2;
  localparam logic [2:0] S_RD_L = 3'd3;
  localparam logic [2:0] S_CALC = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;
  localparam logic [2:0] S_ADV  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [AW-1:0]        ROW_W       = AW'(N + 1);
  localparam logic signed [SW-1:0] SC_MATCH    = SW'(MATCH);
  localparam logic signed [SW-1:0] SC_MISMATCH = SW'(MISMATCH);
  localparam logic signed [SW-1:0] SC_GAP      = SW'(GAP);

  logic [2:0]             state_q, state_d;
  logic signed [SW-1:0]   diag_q, diag_d;
  logic signed [SW-1:0]   up_q, up_d;
  logic [1:0]             a_q, a_d;
  logic [1:0]             b_q, b_d;
  logic signed [SW-1:0]   result_q, result_d;

  logic [AW-1:0]          iw, jw, im1, jm1;
  logic signed [SW-1:0]   sc_d, sc_u, sc_l, best;

`ifdef TRACEBACK_DIR_EN
  logic [1:0] dir_q, dir_d, best_dir;
`endif

  always_comb begin
    iw  = AW'(i);
    jw  = AW'(j);
    im1 = iw - AW'(1);
    jm1 = jw - AW'(1);
  end

  // Left comes straight off rd_data in CALC so the result registers at the end of CALC.
  always_comb begin
    sc_d = diag_q + ((a_q == b_q) ? SC_MATCH : SC_MISMATCH);
    sc_u = up_q + SC_GAP;
    sc_l = rd_data + SC_GAP;
`ifdef TRACEBACK_DIR_EN
    best_dir = 2'b00;
`endif
    if (sc_d >= sc_u && sc_d >= sc_l) begin
      best = sc_d;
    end else if (sc_u >= sc_l) begin
      best = sc_u;
`ifdef TRACEBACK_DIR_EN
      best_dir = 2'b01;
`endif
    end else begin
      best = sc_l;
`ifdef TRACEBACK_DIR_EN
      best_dir = 2'b10;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    diag_d   = diag_q;
    up_d     = up_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef TRACEBACK_DIR_EN
    dir_d    = dir_q;
`endif
    case (state_q)
      S_IDLE: if (start) state_d = S_RD_D;
      S_RD_D: state_d = S_RD_U;
      S_RD_U: begin
        diag_d  = rd_data;
        a_d     = seq_a_data;
        b_d     = seq_b_data;
        state_d = S_RD_L;
      end
      S_RD_L: begin
        up_d    = rd_data;
        state_d = S_CALC;
      end
      S_CALC: begin
        result_d = best;
`ifdef TRACEBACK_DIR_EN
        dir_d    = best_dir;
`endif
        state_d  = S_WR;
      end
      S_WR:   state_d = end_filling ? S_DONE : S_ADV;
      S_ADV:  state_d = S_RD_D;
      S_DONE: if (start) state_d = S_RD_D;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      diag_q   <= '0;
      up_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
`ifdef TRACEBACK_DIR_EN
      dir_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      diag_q   <= diag_d;
      up_q     <= up_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
`ifdef TRACEBACK_DIR_EN
      dir_q    <= dir_d;
`endif
    end
  end

  always_comb begin
    rd_addr    = '0;
    seq_a_addr = '0;
    seq_b_addr = '0;
    wr_addr    = '0;
    case (state_q)
      S_RD_D: begin
        rd_addr    = im1 * ROW_W + jm1;
        seq_a_addr = SAW'(i - IW'(1));
        seq_b_addr = SAW'(j - IW'(1));
      end
      S_RD_U: rd_addr = im1 * ROW_W + jw;
      S_RD_L: rd_addr = iw * ROW_W + jm1;
      S_WR:   wr_addr = iw * ROW_W + jw;
      default: ;
    endcase
  end

  always_comb begin
    en_read      = (state_q != S_IDLE) && (state_q != S_DONE);
    change_index = (state_q == S_ADV);
    wr_en        = (state_q == S_WR);
    done         = (state_q == S_DONE);
    wr_data      = result_q;
`ifdef TRACEBACK_DIR_EN
    dir_data     = dir_q;
`endif
  end

endmodule
